pc_gen_ctrl: RTL



---
 rtl/mmm_pkg.sv | 28 ++
 rtl/pc_gen_ctrl_pc_next_mux.sv | 49 ++++
 rtl/pc_gen_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/mmm_pkg.sv
// Shared fetch-side definitions: machine width, boot address, PC source
// encoding and the PC controller state encoding.
package mmm_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] BOOT_PC = 32'h0000_0100;

   // Source of the most recent PC update, as reported to the fetch stage
   typedef enum logic [1:0] {
      SRC_SEQ     = 2'd0,
      SRC_PRED    = 2'd1,
      SRC_MISPRED = 2'd2,
      SRC_EXCEPT  = 2'd3
   } redirect_src_t;

   // PC controller sequencing states
   typedef enum logic [1:0] {
      BOOT   = 2'd0,
      RUN    = 2'd1,
      BUBBLE = 2'd2
   } pc_ctrl_state_t;

   // Instruction addresses are word aligned, so the low two bits are dropped
   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/pc_gen_ctrl_pc_next_mux.sv
// Next-PC priority selector: exception, then mispredict, then predicted
// taken branch, then sequential PC+4. Every written target is word aligned.
module pc_next_mux
   import mmm_pkg::*;
(
   input  logic            [XLEN-1:0] pc,
   input  logic                       handshake,
   input  logic                       pred_taken,
   input  logic            [XLEN-1:0] pred_target,
   input  logic                       res_mispredict,
   input  logic                       res_taken,
   input  logic            [XLEN-1:0] res_target,
   input  logic            [XLEN-1:0] res_pc,
   input  logic                       except,
   input  logic            [XLEN-1:0] except_vector,
   output logic            [XLEN-1:0] pc_next,
   output redirect_src_t              src_next,
   output logic                       pc_load,
   output logic                       flush
);

   // Pick the highest-priority PC source; a flush redirect ignores the handshake
   always_comb begin
      pc_next  = pc;
      src_next = SRC_SEQ;
      pc_load  = 1'b0;
      flush    = 1'b0;
      if (except) begin
         pc_next  = align_pc(except_vector);
         src_next = SRC_EXCEPT;
         pc_load  = 1'b1;
         flush    = 1'b1;
      end else if (res_mispredict) begin
         pc_next  = align_pc(res_taken ? res_target : (res_pc + XLEN'(4)));
         src_next = SRC_MISPRED;
         pc_load  = 1'b1;
         flush    = 1'b1;
      end else if (pred_taken && handshake) begin
         pc_next  = align_pc(pred_target);
         src_next = SRC_PRED;
         pc_load  = 1'b1;
      end else if (handshake) begin
         pc_next  = align_pc(pc + XLEN'(4));
         src_next = SRC_SEQ;
         pc_load  = 1'b1;
      end
   end

endmodule

// File: rtl/pc_gen_ctrl.sv
// Fetch PC controller: owns the PC register, the BOOT/RUN/BUBBLE sequencer
// and its delay counter. Defining PC_GEN_CTRL_PERF_EN adds saturating
// mispredict/exception event counters with a synchronous clear.
module pc_gen_ctrl
   import mmm_pkg::*;
#(
   parameter int BOOT_DELAY      = 4,
   parameter int REDIRECT_BUBBLE = 1,
   parameter int CNT_W           = 32
)(
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic            fetch_ready_i,
   input  logic            pred_taken_i,
   input  logic [XLEN-1:0] pred_target_i,
   input  logic            res_mispredict_i,
   input  logic            res_taken_i,
   input  logic [XLEN-1:0] res_target_i,
   input  logic [XLEN-1:0] res_pc_i,
   input  logic            except_i,
   input  logic [XLEN-1:0] except_vector_i,
   output logic [XLEN-1:0] pc_o,
   output logic            pc_valid_o,
   output logic            flush_o,
   output logic [1:0]      redirect_src_o
`ifdef PC_GEN_CTRL_PERF_EN
   ,
   input  logic             perf_clr_i,
   output logic [CNT_W-1:0] perf_mispredict_o,
   output logic [CNT_W-1:0] perf_except_o
`endif
);

   localparam int MAX_DELAY = (BOOT_DELAY > REDIRECT_BUBBLE) ? BOOT_DELAY : REDIRECT_BUBBLE;
   localparam int CW        = $clog2(MAX_DELAY + 2);

   // Last counter value spent in each waiting state before moving to RUN
   localparam logic [CW-1:0] BOOT_LAST   = CW'((BOOT_DELAY > 0) ? BOOT_DELAY - 1 : 0);
   localparam logic [CW-1:0] BUBBLE_LAST = CW'((REDIRECT_BUBBLE > 0) ? REDIRECT_BUBBLE - 1 : 0);

   pc_ctrl_state_t  state_q;
   logic [CW-1:0]   cnt_q;
   logic            valid_q;
   logic [XLEN-1:0] pc_q;
   redirect_src_t   src_q;

   logic [XLEN-1:0] pc_next;
   redirect_src_t   src_next;
   logic            pc_load;
   logic            flush;
   logic            handshake;

   assign handshake = valid_q & fetch_ready_i;

   pc_next_mux u_pc_next_mux (
      .pc             (pc_q),
      .handshake      (handshake),
      .pred_taken     (pred_taken_i),
      .pred_target    (pred_target_i),
      .res_mispredict (res_mispredict_i),
      .res_taken      (res_taken_i),
      .res_target     (res_target_i),
      .res_pc         (res_pc_i),
      .except         (except_i),
      .except_vector  (except_vector_i),
      .pc_next        (pc_next),
      .src_next       (src_next),
      .pc_load        (pc_load),
      .flush          (flush)
   );

   // PC and its source tag load together and hold together
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         pc_q  <= BOOT_PC;
         src_q <= SRC_SEQ;
      end else if (pc_load) begin
         pc_q  <= pc_next;
         src_q <= src_next;
      end
   end

   // Sequencer: a flush redirect overrides any state, including the boot delay
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= BOOT;
         cnt_q   <= '0;
         valid_q <= 1'b0;
      end else if (flush) begin
         cnt_q <= '0;
         if (REDIRECT_BUBBLE > 0) begin
            state_q <= BUBBLE;
            valid_q <= 1'b0;
         end else begin
            state_q <= RUN;
            valid_q <= 1'b1;
         end
      end else begin
         case (state_q)
            BOOT: begin
               if (cnt_q == BOOT_LAST) begin
                  state_q <= RUN;
                  valid_q <= 1'b1;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RUN: begin
               valid_q <= 1'b1;
            end
            BUBBLE: begin
               if (cnt_q == BUBBLE_LAST) begin
                  state_q <= RUN;
                  valid_q <= 1'b1;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               state_q <= BOOT;
               valid_q <= 1'b0;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign pc_o           = pc_q;
   assign pc_valid_o     = valid_q;
   assign flush_o        = flush;
   assign redirect_src_o = src_q;

`ifdef PC_GEN_CTRL_PERF_EN
   logic [CNT_W-1:0] perf_mis_q;
   logic [CNT_W-1:0] perf_exc_q;

   // Saturating event counters; an exception masks a same-cycle mispredict
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         perf_mis_q <= '0;
         perf_exc_q <= '0;
      end else if (perf_clr_i) begin
         perf_mis_q <= '0;
         perf_exc_q <= '0;
      end else begin
         if (except_i && !(&perf_exc_q)) begin
            perf_exc_q <= perf_exc_q + 1'b1;
         end
         if (res_mispredict_i && !except_i && !(&perf_mis_q)) begin
            perf_mis_q <= perf_mis_q + 1'b1;
         end
      end
   end

   assign perf_mispredict_o = perf_mis_q;
   assign perf_except_o     = perf_exc_q;
`endif

endmodule
